// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stage (fixed priority, never stalled) and the long-latency unit
// result channel (valid/ready). LU results that lose arbitration are buffered
// in a small FIFO. The block forwards buffered data to decode and requests a
// writeback bubble when buffered entries starve.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   wb_we, wb_addr, wb_data     writeback write request
//   lu_valid, lu_ready,
//   lu_addr, lu_data            long-latency result handshake
//   rf_we, rf_addr, rf_data     register-file write port (combinational)
//   q_addr, q_hit, q_data       forwarding query against live buffered entries
//   stall_req                   registered request for one writeback bubble
//   buf_count                   occupied FIFO slots
module wb_port_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_we,
    input  logic [4:0]                 wb_addr,
    input  logic [31:0]                wb_data,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [4:0]                 lu_addr,
    input  logic [31:0]                lu_data,
    output logic                       rf_we,
    output logic [4:0]                 rf_addr,
    output logic [31:0]                rf_data,
    input  logic [4:0]                 q_addr,
    output logic                       q_hit,
    output logic [31:0]                q_data,
    output logic                       stall_req,
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       e_addr [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [DEPTH-1:0] e_live;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;
    logic [SW-1:0]    starve_nxt;

    logic wb_take;
    logic fifo_ne;
    logic lu_acc;
    logic lu_nz;
    logic pop;
    logic bypass;
    logic push;

    assign buf_count = count;

    // Arbitration and handshake; everything is forced idle while in reset.
    always_comb begin
        fifo_ne  = (count != '0);
        wb_take  = !rst && wb_we && (wb_addr != 5'd0);
        lu_ready = !rst && (count < CW'(DEPTH));
        lu_acc   = lu_valid && lu_ready;
        lu_nz    = (lu_addr != 5'd0);
        pop      = !rst && !wb_take && fifo_ne;
        bypass   = !wb_take && !fifo_ne && lu_acc && lu_nz;
        // Accepted nonzero results that cannot use the port are buffered.
        push     = lu_acc && lu_nz && (wb_take || fifo_ne);
    end

    // Write-port mux in priority order: writeback, FIFO head, LU bypass.
    always_comb begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (wb_take) begin
            rf_we   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
        end else if (pop) begin
            rf_we   = e_live[rd_ptr];
            rf_addr = e_addr[rd_ptr];
            rf_data = e_data[rd_ptr];
        end else if (bypass) begin
            rf_we   = 1'b1;
            rf_addr = lu_addr;
            rf_data = lu_data;
        end
    end

    // Forwarding: walk oldest to youngest so the youngest live match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx    = '0;
        q_hit  = 1'b0;
        q_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && e_live[idx] && (e_addr[idx] == q_addr)) begin
                q_hit  = 1'b1;
                q_data = e_data[idx];
            end
        end
        if (rst || (q_addr == 5'd0)) begin
            q_hit  = 1'b0;
            q_data = 32'd0;
        end
    end

    // Starvation counter: clears on pop or empty FIFO, saturates at STARVE_MAX.
    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || !fifo_ne) begin
            starve_nxt = '0;
        end else if (wb_take && (starve_cnt < SW'(STARVE_MAX))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    // Control state: pointers, occupancy, live bits, starvation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            e_live     <= '0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            // WAW kill first; a same-cycle push is younger and stays live.
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_take && (e_addr[i] == wb_addr)) begin
                    e_live[i] <= 1'b0;
                end
            end
            if (push) begin
                e_live[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            starve_cnt <= starve_nxt;
            stall_req  <= (starve_nxt == SW'(STARVE_MAX));
        end
    end

    // Entry payload storage; validity is tracked by count and live bits.
    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[wr_ptr] <= lu_addr;
            e_data[wr_ptr] <= lu_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_MAX=4). Inputs change
// 1 ns after a rising edge; outputs are sampled 3 ns after the edge.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_we;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_addr;
    logic [31:0]   lu_data;
    logic          rf_we;
    logic [4:0]    rf_addr;
    logic [31:0]   rf_data;
    logic [4:0]    q_addr;
    logic          q_hit;
    logic [31:0]   q_data;
    logic          stall_req;
    logic [CW-1:0] buf_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
        .stall_req(stall_req), .buf_count(buf_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        lu_valid = 1'b0; lu_addr = 5'd0; lu_data = 32'd0;
        q_addr = 5'd0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
    endtask

    task automatic lu(input logic [4:0] a, input logic [31:0] d);
        lu_valid = 1'b1; lu_addr = a; lu_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb(5'd3, 32'h1); lu(5'd5, 32'h2); q_addr = 5'd5;
        tick(); #2;
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL rst_rf_we got %b exp 0", rf_we); end
        vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL rst_lu_ready got %b exp 0", lu_ready); end
        vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL rst_q_hit got %b exp 0", q_hit); end
        tick();
        rst = 1'b0; idle(); #2;
        vectors++; if (buf_count !== CW'(0)) begin miscompares++; $display("FAIL rst_buf_count got %0d exp 0", buf_count); end
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b exp 0", stall_req); end
        vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_lu_ready got %b exp 1", lu_ready); end
    endtask

    task automatic test_bypass();
        lu(5'd5, 32'hDEADBEEF); #2;
        vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL byp_rf_we got %b exp 1", rf_we); end
        vectors++; if (rf_addr !== 5'd5) begin miscompares++; $display("FAIL byp_rf_addr got %0d exp 5", rf_addr); end
        vectors++; if (rf_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL byp_rf_data got %h exp deadbeef", rf_data); end
        tick(); idle(); #2;
        vectors++; if (buf_count !== CW'(0)) begin miscompares++; $display("FAIL byp_buf_count got %0d exp 0", buf_count); end
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL byp_idle_rf_we got %b exp 0", rf_we); end
    endtask

    task automatic test_buffer_forward();
        wb(5'd3, 32'h55); lu(5'd7, 32'h11); #2;
        vectors++; if (rf_addr !== 5'd3 || rf_data !== 32'h55 || rf_we !== 1'b1) begin miscompares++; $display("FAIL buf_wb_write got %b/%0d/%h exp 1/3/55", rf_we, rf_addr, rf_data); end
        vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL buf_lu_ready got %b exp 1", lu_ready); end
        tick(); idle(); q_addr = 5'd7; #2;
        vectors++; if (buf_count !== CW'(1)) begin miscompares++; $display("FAIL buf_count1 got %0d exp 1", buf_count); end
        vectors++; if (q_hit !== 1'b1 || q_data !== 32'h11) begin miscompares++; $display("FAIL buf_fwd got %b/%h exp 1/11", q_hit, q_data); end
        vectors++; if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'h11) begin miscompares++; $display("FAIL buf_pop got %b/%0d/%h exp 1/7/11", rf_we, rf_addr, rf_data); end
        tick(); #2;
        vectors++; if (buf_count !== CW'(0)) begin miscompares++; $display("FAIL buf_count0 got %0d exp 0", buf_count); end
        vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL buf_fwd_gone got %b exp 0", q_hit); end
        idle();
    endtask

    task automatic test_x0();
        lu(5'd0, 32'hABCD); #2;
        vectors++; if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin miscompares++; $display("FAIL x0_lu got ready %b we %b exp 1/0", lu_ready, rf_we); end
        tick(); idle(); #2;
        vectors++; if (buf_count !== CW'(0)) begin miscompares++; $display("FAIL x0_lu_count got %0d exp 0", buf_count); end
        // Writeback to x0 leaves the port free for an LU bypass.
        wb(5'd0, 32'hFFFF); lu(5'd5, 32'h77); #2;
        vectors++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'h77) begin miscompares++; $display("FAIL x0_wb got %b/%0d/%h exp 1/5/77", rf_we, rf_addr, rf_data); end
        tick(); idle(); #2;
        vectors++; if (buf_count !== CW'(0)) begin miscompares++; $display("FAIL x0_wb_count got %0d exp 0", buf_count); end
    endtask

    task automatic test_full_starve();
        wb(5'd1, 32'h100); lu(5'd10, 32'hA1); #2;                        // cycle A
        tick(); lu(5'd10, 32'hA2); #2;                                    // cycle B
        vectors++; if (buf_count !== CW'(1) || lu_ready !== 1'b1) begin miscompares++; $display("FAIL full_b got count %0d ready %b exp 1/1", buf_count, lu_ready); end
        tick(); lu(5'd12, 32'hA3); q_addr = 5'd10; #2;                    // cycle C
        vectors++; if (buf_count !== CW'(2) || lu_ready !== 1'b0) begin miscompares++; $display("FAIL full_c got count %0d ready %b exp 2/0", buf_count, lu_ready); end
        vectors++; if (q_hit !== 1'b1 || q_data !== 32'hA2) begin miscompares++; $display("FAIL youngest_fwd got %b/%h exp 1/a2", q_hit, q_data); end
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL stall_c got %b exp 0", stall_req); end
        tick(); #2;                                                       // cycle D
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL stall_d got %b exp 0", stall_req); end
        tick(); #2;                                                       // cycle E
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL stall_e got %b exp 0", stall_req); end
        tick(); #2;                                                       // cycle F
        vectors++; if (stall_req !== 1'b1) begin miscompares++; $display("FAIL stall_f got %b exp 1", stall_req); end
        wb_we = 1'b0; #1;
        vectors++; if (rf_we !== 1'b1 || rf_addr !== 5'd10 || rf_data !== 32'hA1) begin miscompares++; $display("FAIL full_pop1 got %b/%0d/%h exp 1/10/a1", rf_we, rf_addr, rf_data); end
        vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop_ready got %b exp 0", lu_ready); end
        tick(); #2;                                                       // cycle G
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL stall_clear got %b exp 0", stall_req); end
        vectors++; if (buf_count !== CW'(1) || lu_ready !== 1'b1) begin miscompares++; $display("FAIL full_g got count %0d ready %b exp 1/1", buf_count, lu_ready); end
        vectors++; if (rf_we !== 1'b1 || rf_addr !== 5'd10 || rf_data !== 32'hA2) begin miscompares++; $display("FAIL full_pop2 got %b/%0d/%h exp 1/10/a2", rf_we, rf_addr, rf_data); end
        tick(); lu_valid = 1'b0; #2;                                      // cycle H
        vectors++; if (buf_count !== CW'(1)) begin miscompares++; $display("FAIL pushpop_count got %0d exp 1", buf_count); end
        vectors++; if (rf_we !== 1'b1 || rf_addr !== 5'd12 || rf_data !== 32'hA3) begin miscompares++; $display("FAIL full_pop3 got %b/%0d/%h exp 1/12/a3", rf_we, rf_addr, rf_data); end
        tick(); #2;
        vectors++; if (buf_count !== CW'(0)) begin miscompares++; $display("FAIL full_drain got %0d exp 0", buf_count); end
        idle();
    endtask

    task automatic test_waw_kill();
        wb(5'd4, 32'h44); lu(5'd9, 32'h22);
        tick(); idle(); wb(5'd9, 32'h33); q_addr = 5'd9; #2;
        vectors++; if (q_hit !== 1'b1 || q_data !== 32'h22) begin miscompares++; $display("FAIL kill_pre got %b/%h exp 1/22", q_hit, q_data); end
        tick(); #2;
        vectors++; if (q_hit !== 1'b0 || buf_count !== CW'(1)) begin miscompares++; $display("FAIL kill_post got hit %b count %0d exp 0/1", q_hit, buf_count); end
        // Same-cycle accepted result to the written register is younger.
        wb(5'd9, 32'h34); lu(5'd9, 32'h99);
        tick(); wb_we = 1'b0; lu_valid = 1'b0; #2;
        vectors++; if (q_hit !== 1'b1 || q_data !== 32'h99 || buf_count !== CW'(2)) begin miscompares++; $display("FAIL kill_young got %b/%h count %0d exp 1/99/2", q_hit, q_data, buf_count); end
        vectors++; if (rf_we !== 1'b0 || rf_addr !== 5'd9) begin miscompares++; $display("FAIL kill_dead_pop got %b/%0d exp 0/9", rf_we, rf_addr); end
        tick(); #2;
        vectors++; if (rf_we !== 1'b1 || rf_data !== 32'h99) begin miscompares++; $display("FAIL kill_live_pop got %b/%h exp 1/99", rf_we, rf_data); end
        tick(); #2;
        vectors++; if (buf_count !== CW'(0)) begin miscompares++; $display("FAIL kill_drain got %0d exp 0", buf_count); end
        idle();
    endtask

    task automatic test_reset_mid();
        wb(5'd1, 32'h1); lu(5'd20, 32'h5);
        tick(); lu(5'd21, 32'h6);
        tick(); lu_valid = 1'b0; #2;
        vectors++; if (buf_count !== CW'(2)) begin miscompares++; $display("FAIL mid_fill got %0d exp 2", buf_count); end
        rst = 1'b1; wb_we = 1'b0; #1;
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst_we got %b exp 0", rf_we); end
        tick(); rst = 1'b0; idle(); q_addr = 5'd20; #2;
        vectors++; if (buf_count !== CW'(0) || stall_req !== 1'b0) begin miscompares++; $display("FAIL mid_after got count %0d stall %b exp 0/0", buf_count, stall_req); end
        vectors++; if (rf_we !== 1'b0 || q_hit !== 1'b0) begin miscompares++; $display("FAIL mid_after_port got we %b hit %b exp 0/0", rf_we, q_hit); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_bypass();
        test_buffer_forward();
        test_x0();
        test_full_starve();
        test_waw_kill();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources.
- Source 1 is the in-order writeback stage, which has fixed priority and is never stalled.
- Source 2 is the long-latency execution unit (multiply/divide) result channel, which uses a valid/ready handshake.
- Results that lose arbitration go into a small FIFO. The block provides read-forwarding from that FIFO and requests a pipeline bubble when FIFO entries starve.

Parameters:
DEPTH, 2, number of buffered long-latency results (power of 2, ≥2)
STARVE_MAX, 4, consecutive lost-arbitration cycles before stall_req asserts

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
wb_we  input  1  writeback write enable (active-high, already decoded)
wb_addr  input  5  writeback destination register
wb_data  input  32  writeback data
lu_valid  input  1  long-latency result valid
lu_ready  output  1  result accepted this cycle when lu_valid & lu_ready
lu_addr  input  5  long-latency destination register
lu_data  input  32  long-latency result
rf_we  output  1  register-file write enable
rf_addr  output  5  register-file write address
rf_data  output  32  register-file write data
q_addr  input  5  forwarding query address (decode-stage source register)
q_hit  output  1  q_addr matches a live buffered entry
q_data  output  32  data of the youngest matching live entry
stall_req  output  1  request one writeback bubble
buf_count  output  $clog2(DEPTH)+1  number of occupied FIFO slots

Behaviour:
- One clock domain (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - count, read and write pointers, live bits, starve counter: 0.
  - stall_req = 0.
  - Combinationally while rst = 1: rf_we = 0, lu_ready = 0, q_hit = 0.
- Write-port priority, decided combinationally each cycle:
  1. wb_we & (wb_addr != 0): rf_* driven from wb_*.
  2. Else, FIFO not empty: pop the head. rf_we = head live bit; rf_addr and rf_data come from the head.
  3. Else, lu_valid & lu_ready & (lu_addr != 0): bypass, rf_* driven from lu_*. No push.
  4. Else: rf_we = 0.
- The port is "free" when option 1 is not taken. A pop consumes the free slot even if the head entry is dead.
- lu_ready = (count < DEPTH). It depends only on registered count; a pop in the same cycle does not raise it.
- Push rule: an accepted LU result with lu_addr != 0 is pushed when not bypassed, i.e. when the port is taken by writeback or the FIFO is non-empty.
  - New entry is marked live.
  - Push and pop in the same cycle is allowed; count stays unchanged.
- x0 handling:
  - Writeback writes to x0 never assert rf_we and do not take the port.
  - LU results to x0 are accepted (handshake completes) and discarded; they are never pushed.
- WAW kill: when writeback writes address A (A != 0), every live buffered entry with addr A is marked dead at the clock edge.
  - An LU result accepted in the same cycle is younger and is not killed.
  - Dead entries stay in the FIFO and are popped with rf_we = 0.
- Forwarding: q_hit / q_data search live entries only, and select the youngest match.
  - Same-cycle incoming lu_* and rf_* are not included; the decode-stage bypass handles those.
  - q_addr = 0 gives q_hit = 0.
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and writeback takes the port.
  - It clears on any pop or when the FIFO is empty, and saturates at STARVE_MAX.
  - stall_req is registered: it is 1 in the cycle after starve_cnt reaches STARVE_MAX, and holds until the cycle after a pop occurs.
  - The pipeline answers stall_req by presenting wb_we = 0 for at least one cycle.
- Full FIFO: lu_ready = 0; the LU holds lu_valid and lu_* stable until accepted.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Reset mid-operation: all buffered entries are discarded, with no rf write in the reset cycle. The LU must re-present after reset; an unaccepted result is not lost by this block.

Test Plan:
- Idle port, lu_valid=1, lu_addr=5, lu_data=0xDEADBEEF, wb_we=0 → same cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; buf_count stays 0.
- wb_we=1 wb_addr=3 with LU result addr=7 data=0x11 → rf writes x3. Next cycle (wb_we=0): rf writes x7=0x11, buf_count goes 1→0. While the entry is buffered, q_addr=7 gives q_hit=1, q_data=0x11.
- wb_we held 1 while the LU offers 3 results (DEPTH=2) → two pushes, then lu_ready=0 with buf_count=2.
- Same case continued → stall_req rises 1 cycle after 4 starved cycles. On wb_we=0: pop, then stall_req clears the following cycle.
- Buffer x9=0x22, then wb writes x9=0x33 → entry killed, q_addr=9 gives q_hit=0. The later pop gives rf_we=0, so x9 remains 0x33.
- LU result to x0 → lu_ready handshake completes, rf_we=0, buf_count=0.
- Reset with buf_count=2 → next cycle buf_count=0, stall_req=0, no rf write.
